// File: rtl/rtlola_event_scheduler.sv
// rtlola_event_scheduler: merges input-arrival events and periodic deadlines
// into one time-ordered FIFO and releases the head event to the evaluator
// one per handshake.
module rtlola_event_scheduler #(
  parameter int DATA_W = 64,
  parameter int TS_W   = 32,
  parameter int PERIOD = 500,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] input_0,
  input  logic              new_input_0,
  input  logic              eval_ready,
  output logic              ev_valid,
  output logic [DATA_W-1:0] ev_data,
  output logic [TS_W-1:0]   ev_time,
  output logic              pacing_0,
  output logic              pacing_1,
  output logic              q_push,
  output logic              q_push_valid,
  output logic              q_pop,
  output logic              q_pop_valid,
  output logic [7:0]        overflow_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TICK_W = $clog2(PERIOD);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              has_in;
    logic              per;
    logic [TS_W-1:0]   ts;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            push_entry;
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [TS_W-1:0]   ts;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              not_empty;

  assign tick      = (tick_cnt == TICK_W'(PERIOD - 1));
  assign not_empty = (count != '0);

  // Handshake status and the candidate entry; nothing moves while disabled or in reset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    q_push            = 1'b0;
    q_pop             = 1'b0;
    push_entry.data   = new_input_0 ? input_0 : '0;
    push_entry.has_in = new_input_0;
    push_entry.per    = tick;
    push_entry.ts     = ts;
    if (en && !rst) begin
      q_push = new_input_0 | tick;
      q_pop  = eval_ready;
    end
    q_pop_valid  = q_pop && not_empty;
    // A full queue still accepts when a slot is freed by a pop in the same cycle.
    q_push_valid = q_push && ((count < CNT_W'(DEPTH)) || q_pop_valid);
  end

  // Head presentation: fall-through from registered storage, zeroed when empty.
  always_comb begin
    head     = mem[rd_ptr];
    ev_valid = not_empty;
    ev_data  = not_empty ? head.data : '0;
    ev_time  = not_empty ? head.ts   : '0;
    pacing_0 = not_empty && head.has_in;
    pacing_1 = not_empty && head.per;
  end

  // Time base, deadline counter, FIFO pointers/count and the drop counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      ts           <= '0;
      tick_cnt     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else if (en) begin
      ts       <= ts + TS_W'(1);
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      // Pointers are log2(DEPTH) wide, so the increment wraps on its own.
      if (q_push_valid) wr_ptr <= wr_ptr + PTR_W'(1);
      if (q_pop_valid)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({q_push_valid, q_pop_valid})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (q_push && !q_push_valid && overflow_cnt != 8'hFF)
        overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  // Entry storage; write only on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count gates every read, so stale words are never shown.
    if (q_push_valid) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_rtlola_event_scheduler.sv
// Directed bench for rtlola_event_scheduler with default parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
module tb_rtlola_event_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [63:0] input_0 = '0;
  logic        new_input_0 = 1'b0;
  logic        eval_ready = 1'b0;
  logic        ev_valid;
  logic [63:0] ev_data;
  logic [31:0] ev_time;
  logic        pacing_0, pacing_1;
  logic        q_push, q_push_valid, q_pop, q_pop_valid;
  logic [7:0]  overflow_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  rtlola_event_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .input_0(input_0), .new_input_0(new_input_0),
    .eval_ready(eval_ready), .ev_valid(ev_valid), .ev_data(ev_data), .ev_time(ev_time),
    .pacing_0(pacing_0), .pacing_1(pacing_1), .q_push(q_push), .q_push_valid(q_push_valid),
    .q_pop(q_pop), .q_pop_valid(q_pop_valid), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) next_cycle();
  endtask

  // Leaves the bench at the start of enabled cycle 0 after reset.
  task automatic do_reset();
    rst = 1'b1; en = 1'b1; new_input_0 = 1'b0; eval_ready = 1'b0; input_0 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic strobe(input logic [63:0] v);
    input_0 = v; new_input_0 = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %0b want 0", ev_valid); end
    n_checks++; if ({ev_data, ev_time} !== 96'd0) begin n_fail++; $display("FAIL reset_ev_data_time: got %0h/%0h want 0/0", ev_data, ev_time); end
    n_checks++; if ({pacing_0, pacing_1} !== 2'b00) begin n_fail++; $display("FAIL reset_pacing: got %b want 00", {pacing_0, pacing_1}); end
    n_checks++; if ({q_push, q_push_valid, q_pop, q_pop_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_q_status: got %b want 0000", {q_push, q_push_valid, q_pop, q_pop_valid}); end
    n_checks++; if (overflow_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_overflow: got %0d want 0", overflow_cnt); end
  endtask

  task automatic test_periodic();
    do_reset();
    eval_ready = 1'b1;
    goto(250); @(negedge clk);
    n_checks++; if ({q_push, ev_valid} !== 2'b00) begin n_fail++; $display("FAIL per_idle: got %b want 00", {q_push, ev_valid}); end
    goto(499); @(negedge clk);
    n_checks++; if ({q_push_valid, q_pop_valid} !== 2'b10) begin n_fail++; $display("FAIL per_push_499: got %b want 10", {q_push_valid, q_pop_valid}); end
    goto(500); @(negedge clk);
    n_checks++; if ({ev_valid, pacing_1, pacing_0} !== 3'b110) begin n_fail++; $display("FAIL per_flags_500: got %b want 110", {ev_valid, pacing_1, pacing_0}); end
    n_checks++; if (ev_time !== 32'd499) begin n_fail++; $display("FAIL per_time_500: got %0d want 499", ev_time); end
    n_checks++; if (ev_data !== 64'd0) begin n_fail++; $display("FAIL per_data_500: got %0d want 0", ev_data); end
    n_checks++; if ({q_push, q_pop_valid} !== 2'b01) begin n_fail++; $display("FAIL per_pop_500: got %b want 01", {q_push, q_pop_valid}); end
    goto(501); @(negedge clk);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL per_empty_501: got %0b want 0", ev_valid); end
    goto(998); @(negedge clk);
    n_checks++; if (q_push !== 1'b0) begin n_fail++; $display("FAIL per_no_tick_998: got %0b want 0", q_push); end
    goto(999); @(negedge clk);
    n_checks++; if (q_push_valid !== 1'b1) begin n_fail++; $display("FAIL per_push_999: got %0b want 1", q_push_valid); end
    goto(1000); @(negedge clk);
    n_checks++; if ({ev_valid, ev_time} !== {1'b1, 32'd999}) begin n_fail++; $display("FAIL per_time_1000: got %0b/%0d want 1/999", ev_valid, ev_time); end
  endtask

  task automatic test_single_input();
    do_reset();
    eval_ready = 1'b1;
    goto(10); strobe(64'd1); @(negedge clk);
    n_checks++; if ({q_push, q_push_valid, q_pop, q_pop_valid} !== 4'b1110) begin n_fail++; $display("FAIL in_push_10: got %b want 1110", {q_push, q_push_valid, q_pop, q_pop_valid}); end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL in_no_bypass_10: got %0b want 0", ev_valid); end
    next_cycle(); new_input_0 = 1'b0; @(negedge clk);
    n_checks++; if ({ev_valid, pacing_0, pacing_1} !== 3'b110) begin n_fail++; $display("FAIL in_flags_11: got %b want 110", {ev_valid, pacing_0, pacing_1}); end
    n_checks++; if ({ev_data, ev_time} !== {64'd1, 32'd10}) begin n_fail++; $display("FAIL in_data_time_11: got %0d/%0d want 1/10", ev_data, ev_time); end
    n_checks++; if (q_pop_valid !== 1'b1) begin n_fail++; $display("FAIL in_pop_11: got %0b want 1", q_pop_valid); end
    next_cycle(); @(negedge clk);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL in_empty_12: got %0b want 0", ev_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    goto(499); strobe(64'd7); @(negedge clk);
    n_checks++; if ({q_push, q_push_valid} !== 2'b11) begin n_fail++; $display("FAIL sim_push_499: got %b want 11", {q_push, q_push_valid}); end
    next_cycle(); new_input_0 = 1'b0; eval_ready = 1'b1; @(negedge clk);
    n_checks++; if ({ev_valid, pacing_0, pacing_1} !== 3'b111) begin n_fail++; $display("FAIL sim_flags_500: got %b want 111", {ev_valid, pacing_0, pacing_1}); end
    n_checks++; if ({ev_data, ev_time} !== {64'd7, 32'd499}) begin n_fail++; $display("FAIL sim_data_time_500: got %0d/%0d want 7/499", ev_data, ev_time); end
    n_checks++; if (q_push_valid !== 1'b0) begin n_fail++; $display("FAIL sim_single_pulse_500: got %0b want 0", q_push_valid); end
    next_cycle(); @(negedge clk);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL sim_one_entry_501: got %0b want 0", ev_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      goto(4 + i); strobe(64'(i)); @(negedge clk);
      n_checks++; if ({q_push, q_push_valid} !== {1'b1, (i <= 4)}) begin n_fail++; $display("FAIL ovf_push_%0d: got %b want 1%0b", i, {q_push, q_push_valid}, (i <= 4)); end
    end
    n_checks++; if (overflow_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_cnt_before: got %0d want 0", overflow_cnt); end
    next_cycle(); new_input_0 = 1'b0; eval_ready = 1'b1; @(negedge clk);
    n_checks++; if (overflow_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_cnt_after: got %0d want 1", overflow_cnt); end
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin next_cycle(); @(negedge clk); end
      n_checks++; if ({ev_valid, q_pop_valid, ev_data} !== {2'b11, 64'(i)}) begin n_fail++; $display("FAIL ovf_pop_%0d: got %b/%0d want 11/%0d", i, {ev_valid, q_pop_valid}, ev_data, i); end
    end
    next_cycle(); @(negedge clk);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %0b want 0", ev_valid); end
  endtask

  task automatic test_full_concurrent_pop();
    logic [63:0] exp_vals [4];
    exp_vals[0] = 64'd2; exp_vals[1] = 64'd3; exp_vals[2] = 64'd4; exp_vals[3] = 64'd9;
    do_reset();
    for (int i = 1; i <= 4; i++) begin goto(4 + i); strobe(64'(i)); end
    goto(9); strobe(64'd9); eval_ready = 1'b1; @(negedge clk);
    n_checks++; if ({q_push_valid, q_pop_valid} !== 2'b11) begin n_fail++; $display("FAIL full_push_pop: got %b want 11", {q_push_valid, q_pop_valid}); end
    n_checks++; if (ev_data !== 64'd1) begin n_fail++; $display("FAIL full_head: got %0d want 1", ev_data); end
    // Queue must still be full: a push without a pop is rejected.
    next_cycle(); strobe(64'd11); eval_ready = 1'b0; @(negedge clk);
    n_checks++; if ({q_push, q_push_valid, overflow_cnt} !== {2'b10, 8'd0}) begin n_fail++; $display("FAIL full_still_full: got %b/%0d want 10/0", {q_push, q_push_valid}, overflow_cnt); end
    next_cycle(); new_input_0 = 1'b0; eval_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk);
      n_checks++; if ({ev_valid, ev_data} !== {1'b1, exp_vals[i]}) begin n_fail++; $display("FAIL full_order_%0d: got %0b/%0d want 1/%0d", i, ev_valid, ev_data, exp_vals[i]); end
    end
    n_checks++; if (overflow_cnt !== 8'd1) begin n_fail++; $display("FAIL full_ovf: got %0d want 1", overflow_cnt); end
    next_cycle(); @(negedge clk);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %0b want 0", ev_valid); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    goto(10); strobe(64'd3);
    next_cycle(); new_input_0 = 1'b0;
    goto(20); en = 1'b0;
    goto(50); strobe(64'd5); @(negedge clk);
    n_checks++; if ({q_push, q_push_valid} !== 2'b00) begin n_fail++; $display("FAIL en_no_push: got %b want 00", {q_push, q_push_valid}); end
    next_cycle(); new_input_0 = 1'b0;
    goto(60); eval_ready = 1'b1; @(negedge clk);
    n_checks++; if ({q_pop, q_pop_valid} !== 2'b00) begin n_fail++; $display("FAIL en_no_pop: got %b want 00", {q_pop, q_pop_valid}); end
    n_checks++; if ({ev_valid, ev_data, ev_time} !== {1'b1, 64'd3, 32'd10}) begin n_fail++; $display("FAIL en_head_held: got %0b/%0d/%0d want 1/3/10", ev_valid, ev_data, ev_time); end
    next_cycle(); eval_ready = 1'b0;
    goto(120); en = 1'b1;
    goto(598); @(negedge clk);
    n_checks++; if ({q_push, overflow_cnt} !== {1'b0, 8'd0}) begin n_fail++; $display("FAIL en_tick_not_early: got %0b/%0d want 0/0", q_push, overflow_cnt); end
    goto(599); @(negedge clk);
    n_checks++; if (q_push_valid !== 1'b1) begin n_fail++; $display("FAIL en_tick_delayed: got %0b want 1", q_push_valid); end
    next_cycle(); eval_ready = 1'b1; @(negedge clk);
    n_checks++; if (ev_time !== 32'd10) begin n_fail++; $display("FAIL en_old_head: got %0d want 10", ev_time); end
    next_cycle(); eval_ready = 1'b0; strobe(64'd21); @(negedge clk);
    n_checks++; if ({pacing_1, ev_time} !== {1'b1, 32'd499}) begin n_fail++; $display("FAIL en_ts_frozen: got %0b/%0d want 1/499", pacing_1, ev_time); end
    next_cycle(); strobe(64'd22);
    next_cycle(); strobe(64'd23);
    next_cycle(); strobe(64'd24);
    next_cycle(); new_input_0 = 1'b0; eval_ready = 1'b1; @(negedge clk);
    n_checks++; if (overflow_cnt !== 8'd1) begin n_fail++; $display("FAIL en_ovf_pre_rst: got %0d want 1", overflow_cnt); end
    next_cycle(); eval_ready = 1'b0; rst = 1'b1; @(negedge clk);
    n_checks++; if ({ev_valid, ev_time} !== {1'b1, 32'd501}) begin n_fail++; $display("FAIL en_head_pre_rst: got %0b/%0d want 1/501", ev_valid, ev_time); end
    next_cycle(); rst = 1'b0; @(negedge clk);
    n_checks++; if ({ev_valid, overflow_cnt, ev_time} !== {1'b0, 8'd0, 32'd0}) begin n_fail++; $display("FAIL en_after_rst: got %0b/%0d/%0d want 0/0/0", ev_valid, overflow_cnt, ev_time); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_single_input();
    test_simultaneous();
    test_overflow();
    test_full_concurrent_pop();
    test_enable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtlola_event_scheduler.md
# rtlola_event_scheduler

Front-end controller for the generated RTLola monitor. It merges event-based input arrivals (`new_input_0`) with an internally generated periodic deadline into a single time-ordered event queue, and releases one event per handshake to the evaluation pipeline. It drives the pacing flags that tell the evaluator which streams to compute, and it reports push/pop activity on the `q_*` status lines that the monitor already exposes.

## Interface
Parameters:
- `DATA_W`, 64: width of the input stream value.
- `TS_W`, 32: width of the event timestamp, in enabled clock cycles.
- `PERIOD`, 500: enabled cycles between periodic deadlines; must be ≥ 2.
- `DEPTH`, 4: queue entries; must be a power of two and ≥ 2.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: global enable; low freezes all state.
- `input_0` in DATA_W: signed input value, sampled when `new_input_0`=1.
- `new_input_0` in 1: one-cycle input arrival strobe.
- `eval_ready` in 1: evaluator accepts the head event this cycle.
- `ev_valid` out 1: queue non-empty; head event presented.
- `ev_data` out DATA_W: head input value; 0 when the head has no input.
- `ev_time` out TS_W: timestamp captured at push.
- `pacing_0` out 1: `ev_valid` & head has input (event-based stream).
- `pacing_1` out 1: `ev_valid` & head is periodic (periodic stream).
- `q_push` out 1: push requested this cycle.
- `q_push_valid` out 1: push accepted this cycle.
- `q_pop` out 1: pop requested this cycle.
- `q_pop_valid` out 1: pop performed this cycle.
- `overflow_cnt` out 8: count of dropped events, saturating.

## Operation
- `ts` counter: 0 in the first enabled cycle after reset; +1 per enabled cycle; wraps modulo 2^TS_W.
- `tick_cnt` counter: counts 0..PERIOD-1. `tick`=1 in the cycle where `tick_cnt`=PERIOD-1; `tick_cnt` then returns to 0.
- Candidate event each enabled cycle:
  - `has_in` = `new_input_0`; `per` = `tick`.
  - `q_push` = `has_in` | `per`.
  - A simultaneous input and tick form ONE entry with both flags set.
- Entry contents: {`input_0` if `has_in`, else 0; `has_in`; `per`; `ts`}.
- Push is accepted (`q_push_valid`=1) when `q_push` and (`count`<DEPTH, or a pop is performed in the same cycle).
  - A rejected push is dropped; `overflow_cnt` increments and saturates at 255.
- Pop:
  - `q_pop` = `en` & `eval_ready`.
  - `q_pop_valid` = `q_pop` & (`count`≠0).
  - No bypass: an event pushed into an empty queue is not poppable in its push cycle.
- Head presentation: first-word fall-through from registered storage. `ev_*` and `pacing_*` reflect the head entry, and are 0 when empty.
- FIFO: circular buffer with read/write pointers of log2(DEPTH) bits, wrapping, plus a `count` register (0..DEPTH). Events are kept strictly in push order.
- `en`=0:
  - All counters, pointers and storage hold.
  - `q_push`, `q_push_valid`, `q_pop`, `q_pop_valid` are 0.
  - A strobe arriving while disabled is ignored and not counted as overflow.
  - `ev_*` continue to show the head.

## Timing
- Reset (cycle after `rst`=1 sampled): `count`, pointers, `ts`, `tick_cnt` and `overflow_cnt` are 0. Every output is 0.
- `rst` asserted mid-operation: queue contents are discarded and all outputs are 0 on the next cycle. `rst` has priority over `en`.
- Push-to-visible latency: push in cycle t → `ev_valid` in t+1 (if the queue was empty).
- Pop in cycle t → the next entry, or empty, is shown in t+1.
- Throughput: 1 push and 1 pop per cycle sustained.
- `q_*` status outputs are combinational from current state and inputs. `ev_*`/`pacing_*` are combinational from registers only.

## Test plan
- Periodic only: PERIOD=500, `eval_ready`=1, no inputs after reset → `q_push_valid`=1 in enabled cycle 499. In cycle 500: `ev_valid`=1, `pacing_1`=1, `pacing_0`=0, `ev_time`=499, `ev_data`=0. The next tick occurs at cycle 999.
- Single input: `input_0`=1 strobed in cycle 10 → in cycle 11: `ev_valid`=1, `pacing_0`=1, `pacing_1`=0, `ev_data`=1, `ev_time`=10. The entry is popped in cycle 11, and `ev_valid`=0 in cycle 12.
- Simultaneous events: `input_0`=7 strobed in cycle 499 → exactly one entry, with `pacing_0`=`pacing_1`=1, `ev_data`=7, `ev_time`=499. `q_push_valid` pulses once.
- Overflow: `eval_ready`=0, DEPTH=4, inputs 1..5 on five consecutive cycles.
  - Fifth cycle: `q_push`=1, `q_push_valid`=0, then `overflow_cnt`=1.
  - Then `eval_ready`=1 → pops 1,2,3,4 in order on successive cycles.
- Full with concurrent pop: queue full, `eval_ready`=1 and an input strobe of value 9 in the same cycle → `q_push_valid`=1, `q_pop_valid`=1, `count` stays 4, `overflow_cnt` unchanged. Value 9 is popped after the three older entries.
- Enable/reset: `en`=0 for 100 cycles mid-run, with a strobe → no push, `overflow_cnt` unchanged, `ts` and `tick_cnt` frozen, and the tick is delayed by 100 cycles. Then `rst`=1 with 3 entries queued → `ev_valid`=0 and `overflow_cnt`=0 on the next cycle.
